// File: rtl/snitch_acc_pkg.sv
// Shared definitions for the accelerator response path: index/width helpers
// and the layout of one buffered response entry.
package snitch_acc_pkg;

  // Width needed to index n items; a single item still gets one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 32'd1) ? unsigned'($clog2(n)) : 32'd1;
  endfunction

  // Response ID width seen by the shared unit: core-local ID plus core select.
  function automatic int unsigned ext_id_width(input int unsigned id_width,
                                               input int unsigned core_count);
    return id_width + idx_width(core_count);
  endfunction

  // Bits of one stored entry: {id, data, error}.
  function automatic int unsigned entry_width(input int unsigned id_width,
                                              input int unsigned data_width);
    return id_width + data_width + 32'd1;
  endfunction

  localparam int unsigned DefaultIdWidth   = 5;
  localparam int unsigned DefaultDataWidth = 32;

  // Entry layout for the default configuration; parameterised instances use
  // the same field order packed into an entry_width() vector.
  typedef struct packed {
    logic [DefaultIdWidth-1:0]   id;
    logic [DefaultDataWidth-1:0] data;
    logic                        error;
  } acc_rsp_t;

endpackage

// File: rtl/snitch_acc_rsp_fifo.sv
// Single-core response FIFO with full/empty tracking.
// Optional feature: SNITCH_ACC_RSP_BYPASS_EN lets a response to an empty FIFO
// go straight to a ready core in the same cycle without being stored.
module snitch_acc_rsp_fifo #(
  parameter int unsigned Width = 38,
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_valid_i,
  output logic             push_ready_o,
  input  logic [Width-1:0] push_data_i,
  output logic             pop_valid_o,
  input  logic             pop_ready_i,
  output logic [Width-1:0] pop_data_o
);

  localparam int unsigned PtrWidth  = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned FillWidth = $clog2(Depth + 1);
  localparam logic [PtrWidth-1:0]  LastPtr  = PtrWidth'(Depth - 1);
  localparam logic [FillWidth-1:0] FullFill = FillWidth'(Depth);

  logic [Width-1:0]     mem_q [Depth];
  logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FillWidth-1:0] fill_q, fill_d;
  logic                 full, empty, bypass, push_en, pop_en;

  assign full  = (fill_q == FullFill);
  assign empty = (fill_q == '0);

`ifdef SNITCH_ACC_RSP_BYPASS_EN
  assign bypass = empty & push_valid_i & pop_ready_i;
`else
  assign bypass = 1'b0;
`endif

  // A full FIFO refuses the push even if the head pops this cycle.
  assign push_ready_o = ~full;
  assign push_en      = push_valid_i & ~full & ~bypass;
  assign pop_en       = ~empty & pop_ready_i;

  assign pop_valid_o = ~empty | bypass;
  assign pop_data_o  = bypass ? push_data_i : mem_q[rd_ptr_q];

  // Pointer advance with modulo-Depth wrap and fill-level bookkeeping.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (push_en) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    if (pop_en)  rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    if (push_en && !pop_en)      fill_d = fill_q + 1'b1;
    else if (!push_en && pop_en) fill_d = fill_q - 1'b1;
  end

  // Storage and pointer registers; reset clears entries so idle outputs read zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      if (push_en) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/snitch_acc_rsp_buffer.sv
// Per-core response buffering in front of a shared accelerator.
// Each core gets Depth credits; a request is only forwarded to the shared
// arbiter when a FIFO slot is guaranteed for its response, so a stalled core
// can never block responses to the others.
// Optional feature: SNITCH_ACC_RSP_BYPASS_EN (see snitch_acc_rsp_fifo).
module snitch_acc_rsp_buffer
  import snitch_acc_pkg::*;
#(
  parameter int unsigned CoreCount = 4,
  parameter int unsigned IdWidth   = 5,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 2,
  localparam int unsigned LogCoreCount = idx_width(CoreCount),
  localparam int unsigned ExtIdWidth   = IdWidth + LogCoreCount
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [CoreCount-1:0]           core_qvalid_i,
  output logic [CoreCount-1:0]           core_qready_o,
  output logic [CoreCount-1:0]           arb_qvalid_o,
  input  logic [CoreCount-1:0]           arb_qready_i,
  input  logic                           rsp_valid_i,
  output logic                           rsp_ready_o,
  input  logic [ExtIdWidth-1:0]          rsp_id_i,
  input  logic [DataWidth-1:0]           rsp_data_i,
  input  logic                           rsp_error_i,
  output logic [CoreCount-1:0]           core_pvalid_o,
  input  logic [CoreCount-1:0]           core_pready_i,
  output logic [CoreCount*IdWidth-1:0]   core_pid_o,
  output logic [CoreCount*DataWidth-1:0] core_pdata_o,
  output logic [CoreCount-1:0]           core_perror_o
);

  localparam int unsigned EntryWidth = entry_width(IdWidth, DataWidth);
  localparam int unsigned CntWidth   = $clog2(Depth + 1);
  localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(Depth);

  logic [LogCoreCount-1:0] rsp_sel;
  logic [31:0]             rsp_sel_ext;
  logic [EntryWidth-1:0]   rsp_entry;
  logic [CoreCount-1:0]    push_valid;
  logic [CoreCount-1:0]    push_ready;

  assign rsp_sel     = rsp_id_i[ExtIdWidth-1:IdWidth];
  assign rsp_sel_ext = 32'(rsp_sel);
  assign rsp_entry   = {rsp_id_i[IdWidth-1:0], rsp_data_i, rsp_error_i};

  // Ready reflects only the addressed FIFO; out-of-range selects are sunk.
  always_comb begin
    rsp_ready_o = 1'b1;
    for (int i = 0; i < CoreCount; i++) begin
      if (rsp_sel_ext == 32'(i)) rsp_ready_o = push_ready[i];
    end
  end

  for (genvar g = 0; g < CoreCount; g++) begin : gen_core
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [EntryWidth-1:0] head;
    logic                  credit_ok, issue, retire;

    assign push_valid[g] = rsp_valid_i & (rsp_sel_ext == 32'(g));

    assign credit_ok        = (cnt_q < DepthCnt);
    assign arb_qvalid_o[g]  = core_qvalid_i[g] & credit_ok;
    assign core_qready_o[g] = arb_qready_i[g] & credit_ok;

    assign issue  = core_qvalid_i[g] & core_qready_o[g];
    assign retire = core_pvalid_o[g] & core_pready_i[g];

    // Credit update; a stray response with no outstanding request cannot underflow.
    always_comb begin
      cnt_d = cnt_q;
      if (issue && !retire)                   cnt_d = cnt_q + 1'b1;
      else if (!issue && retire && cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end

    // Credit register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
    end

    snitch_acc_rsp_fifo #(
      .Width (EntryWidth),
      .Depth (Depth)
    ) i_fifo (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .push_valid_i (push_valid[g]),
      .push_ready_o (push_ready[g]),
      .push_data_i  (rsp_entry),
      .pop_valid_o  (core_pvalid_o[g]),
      .pop_ready_i  (core_pready_i[g]),
      .pop_data_o   (head)
    );

    assign core_pid_o[g*IdWidth +: IdWidth]       = head[EntryWidth-1 -: IdWidth];
    assign core_pdata_o[g*DataWidth +: DataWidth] = head[DataWidth:1];
    assign core_perror_o[g]                       = head[0];
  end

endmodule

// File: tb/tb_snitch_acc_rsp_buffer.sv
// Directed bench for snitch_acc_rsp_buffer: a Depth=2 instance and a Depth=4
// instance share all inputs; each scenario starts from reset.
module tb_snitch_acc_rsp_buffer;

  logic         clk, rst_n;
  logic [3:0]   qvalid, arb_qready, pready;
  logic         rsp_valid, rsp_err;
  logic [6:0]   rsp_id;
  logic [31:0]  rsp_data;

  logic [3:0]   qready, arb_qvalid, pvalid, perror;
  logic         rsp_ready;
  logic [19:0]  pid;
  logic [127:0] pdata;

  logic [3:0]   qready4, arb_qvalid4, pvalid4, perror4;
  logic         rsp_ready4;
  logic [19:0]  pid4;
  logic [127:0] pdata4;

  int vec_cnt = 0;
  int err_cnt = 0;

  snitch_acc_rsp_buffer #(.CoreCount(4), .IdWidth(5), .DataWidth(32), .Depth(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .core_qvalid_i(qvalid), .core_qready_o(qready),
    .arb_qvalid_o(arb_qvalid), .arb_qready_i(arb_qready),
    .rsp_valid_i(rsp_valid), .rsp_ready_o(rsp_ready),
    .rsp_id_i(rsp_id), .rsp_data_i(rsp_data), .rsp_error_i(rsp_err),
    .core_pvalid_o(pvalid), .core_pready_i(pready),
    .core_pid_o(pid), .core_pdata_o(pdata), .core_perror_o(perror)
  );

  snitch_acc_rsp_buffer #(.CoreCount(4), .IdWidth(5), .DataWidth(32), .Depth(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n),
    .core_qvalid_i(qvalid), .core_qready_o(qready4),
    .arb_qvalid_o(arb_qvalid4), .arb_qready_i(arb_qready),
    .rsp_valid_i(rsp_valid), .rsp_ready_o(rsp_ready4),
    .rsp_id_i(rsp_id), .rsp_data_i(rsp_data), .rsp_error_i(rsp_err),
    .core_pvalid_o(pvalid4), .core_pready_i(pready),
    .core_pid_o(pid4), .core_pdata_o(pdata4), .core_perror_o(perror4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0; qvalid = '0; arb_qready = 4'hF; pready = '0;
    rsp_valid = 1'b0; rsp_id = '0; rsp_data = '0; rsp_err = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; qvalid = 4'b1010; arb_qready = 4'h0; pready = '0;
    rsp_valid = 1'b0; rsp_id = '0; rsp_data = '0; rsp_err = 1'b0;
    #1;
    vec_cnt++; if (pvalid !== 4'b0000) begin err_cnt++; $display("FAIL rst_pvalid: got %b exp %b", pvalid, 4'b0000); end
    vec_cnt++; if (rsp_ready !== 1'b1) begin err_cnt++; $display("FAIL rst_rsp_ready: got %b exp 1", rsp_ready); end
    vec_cnt++; if (arb_qvalid !== 4'b1010) begin err_cnt++; $display("FAIL rst_arb_qvalid: got %b exp %b", arb_qvalid, 4'b1010); end
    vec_cnt++; if (qready !== 4'b0000) begin err_cnt++; $display("FAIL rst_qready: got %b exp %b", qready, 4'b0000); end
    vec_cnt++; if (pid !== 20'h0) begin err_cnt++; $display("FAIL rst_pid: got %h exp 0", pid); end
    vec_cnt++; if (pdata !== 128'h0) begin err_cnt++; $display("FAIL rst_pdata: got %h exp 0", pdata); end
    vec_cnt++; if (perror !== 4'b0000) begin err_cnt++; $display("FAIL rst_perror: got %b exp 0", perror); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; qvalid = '0; arb_qready = 4'hF; #1;
    vec_cnt++; if (qready !== 4'hF) begin err_cnt++; $display("FAIL post_rst_qready: got %b exp %b", qready, 4'hF); end
    vec_cnt++; if (pvalid !== 4'b0000) begin err_cnt++; $display("FAIL post_rst_pvalid: got %b exp 0", pvalid); end
    vec_cnt++; if (rsp_ready !== 1'b1) begin err_cnt++; $display("FAIL post_rst_rsp_ready: got %b exp 1", rsp_ready); end
  endtask

  task automatic test_credit_block();
    do_reset();
    @(negedge clk); qvalid = 4'b0010; #1;
    vec_cnt++; if (qready[1] !== 1'b1 || arb_qvalid[1] !== 1'b1) begin err_cnt++; $display("FAIL credit_first: got qready=%b arb=%b exp 1 1", qready[1], arb_qvalid[1]); end
    @(negedge clk); #1;
    vec_cnt++; if (qready[1] !== 1'b1 || arb_qvalid[1] !== 1'b1) begin err_cnt++; $display("FAIL credit_second: got qready=%b arb=%b exp 1 1", qready[1], arb_qvalid[1]); end
    @(negedge clk); #1;
    vec_cnt++; if (qready[1] !== 1'b0 || arb_qvalid[1] !== 1'b0) begin err_cnt++; $display("FAIL credit_third_blocked: got qready=%b arb=%b exp 0 0", qready[1], arb_qvalid[1]); end
    vec_cnt++; if (qready[0] !== 1'b1) begin err_cnt++; $display("FAIL credit_other_core: got %b exp 1", qready[0]); end
    vec_cnt++; if (qready4[1] !== 1'b1) begin err_cnt++; $display("FAIL credit_depth4: got %b exp 1", qready4[1]); end
    qvalid = '0;
  endtask

  task automatic test_stall_isolation();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); rsp_valid = 1'b1; rsp_id = {2'd0, 5'(k + 1)}; rsp_data = 32'hA0 + 32'(k); #1;
      vec_cnt++; if (rsp_ready !== 1'b1) begin err_cnt++; $display("FAIL stall_fill_ready%0d: got %b exp 1", k, rsp_ready); end
    end
    @(negedge clk); rsp_id = {2'd0, 5'd9}; rsp_data = 32'hBAD; #1;
    vec_cnt++; if (rsp_ready !== 1'b0) begin err_cnt++; $display("FAIL stall_full_ready: got %b exp 0", rsp_ready); end
    rsp_id = {2'd2, 5'd7}; rsp_data = 32'hDEAD; rsp_err = 1'b1; #1;
    vec_cnt++; if (rsp_ready !== 1'b1) begin err_cnt++; $display("FAIL stall_other_ready: got %b exp 1", rsp_ready); end
    vec_cnt++; if (pvalid[2] !== 1'b0) begin err_cnt++; $display("FAIL stall_latency: got %b exp 0", pvalid[2]); end
    @(negedge clk); rsp_valid = 1'b0; rsp_err = 1'b0; #1;
    vec_cnt++; if (pvalid[2] !== 1'b1) begin err_cnt++; $display("FAIL stall_c2_valid: got %b exp 1", pvalid[2]); end
    vec_cnt++; if (pid[14:10] !== 5'd7) begin err_cnt++; $display("FAIL stall_c2_id: got %0d exp 7", pid[14:10]); end
    vec_cnt++; if (pdata[95:64] !== 32'hDEAD) begin err_cnt++; $display("FAIL stall_c2_data: got %h exp dead", pdata[95:64]); end
    vec_cnt++; if (perror[2] !== 1'b1) begin err_cnt++; $display("FAIL stall_c2_err: got %b exp 1", perror[2]); end
    vec_cnt++; if (pvalid[0] !== 1'b1 || pdata[31:0] !== 32'hA0 || pid[4:0] !== 5'd1) begin err_cnt++; $display("FAIL stall_c0_head: got v=%b d=%h id=%0d exp 1 a0 1", pvalid[0], pdata[31:0], pid[4:0]); end
    pready = 4'b0001;
    @(negedge clk); #1;
    vec_cnt++; if (pvalid[0] !== 1'b1 || pdata[31:0] !== 32'hA1 || pid[4:0] !== 5'd2) begin err_cnt++; $display("FAIL stall_c0_second: got v=%b d=%h id=%0d exp 1 a1 2", pvalid[0], pdata[31:0], pid[4:0]); end
    @(negedge clk); pready = '0; #1;
    vec_cnt++; if (pvalid[0] !== 1'b0) begin err_cnt++; $display("FAIL stall_c0_drained: got %b exp 0", pvalid[0]); end
    vec_cnt++; if (pvalid[2] !== 1'b1) begin err_cnt++; $display("FAIL stall_c2_held: got %b exp 1", pvalid[2]); end
  endtask

  task automatic test_pop_issue();
    do_reset();
    @(negedge clk); qvalid = 4'b1000; #1;
    vec_cnt++; if (qready[3] !== 1'b1) begin err_cnt++; $display("FAIL popiss_issue0: got %b exp 1", qready[3]); end
    @(negedge clk);
    @(negedge clk); qvalid = '0; rsp_valid = 1'b1; rsp_id = {2'd3, 5'd3}; rsp_data = 32'h33;
    @(negedge clk); rsp_id = {2'd3, 5'd4}; rsp_data = 32'h34;
    @(negedge clk); rsp_valid = 1'b0; qvalid = 4'b1000; pready = 4'b1000; #1;
    vec_cnt++; if (qready[3] !== 1'b0 || arb_qvalid[3] !== 1'b0) begin err_cnt++; $display("FAIL popiss_full_credit: got qready=%b arb=%b exp 0 0", qready[3], arb_qvalid[3]); end
    vec_cnt++; if (pvalid[3] !== 1'b1 || pdata[127:96] !== 32'h33) begin err_cnt++; $display("FAIL popiss_head0: got v=%b d=%h exp 1 33", pvalid[3], pdata[127:96]); end
    @(negedge clk); #1;
    vec_cnt++; if (qready[3] !== 1'b1) begin err_cnt++; $display("FAIL popiss_after_pop: got %b exp 1", qready[3]); end
    vec_cnt++; if (pvalid[3] !== 1'b1 || pdata[127:96] !== 32'h34 || pid[19:15] !== 5'd4) begin err_cnt++; $display("FAIL popiss_head1: got v=%b d=%h id=%0d exp 1 34 4", pvalid[3], pdata[127:96], pid[19:15]); end
    @(negedge clk); pready = '0; #1;
    vec_cnt++; if (qready[3] !== 1'b1) begin err_cnt++; $display("FAIL popiss_cnt_held: got %b exp 1", qready[3]); end
    vec_cnt++; if (pvalid[3] !== 1'b0) begin err_cnt++; $display("FAIL popiss_empty: got %b exp 0", pvalid[3]); end
    @(negedge clk); qvalid = '0; #1;
    vec_cnt++; if (qready[3] !== 1'b0) begin err_cnt++; $display("FAIL popiss_refill: got %b exp 0", qready[3]); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); rsp_valid = 1'b1; rsp_id = {2'd0, 5'(k + 1)}; rsp_data = 32'h100 + 32'(k);
      pready = (k >= 3) ? 4'b0001 : 4'b0000; #1;
      vec_cnt++; if (rsp_ready4 !== 1'b1) begin err_cnt++; $display("FAIL wrap_ready%0d: got %b exp 1", k, rsp_ready4); end
      if (k >= 3) begin
        vec_cnt++; if (pdata4[31:0] !== 32'h100 + 32'(k - 3)) begin err_cnt++; $display("FAIL wrap_pop%0d: got %h exp %h", k, pdata4[31:0], 32'h100 + 32'(k - 3)); end
      end
    end
    for (int k = 2; k < 5; k++) begin
      @(negedge clk); rsp_valid = 1'b0; pready = 4'b0001; #1;
      vec_cnt++; if (pvalid4[0] !== 1'b1) begin err_cnt++; $display("FAIL wrap_valid%0d: got %b exp 1", k, pvalid4[0]); end
      vec_cnt++; if (pdata4[31:0] !== 32'h100 + 32'(k)) begin err_cnt++; $display("FAIL wrap_data%0d: got %h exp %h", k, pdata4[31:0], 32'h100 + 32'(k)); end
      vec_cnt++; if (pid4[4:0] !== 5'(k + 1)) begin err_cnt++; $display("FAIL wrap_id%0d: got %0d exp %0d", k, pid4[4:0], k + 1); end
    end
    @(negedge clk); #1;
    vec_cnt++; if (pvalid4[0] !== 1'b0) begin err_cnt++; $display("FAIL wrap_drained: got %b exp 0", pvalid4[0]); end
    pready = '0;
  endtask

  task automatic test_async_reset();
    do_reset();
    @(negedge clk); rsp_valid = 1'b1; rsp_id = {2'd2, 5'd1}; rsp_data = 32'h55;
    @(negedge clk); rsp_valid = 1'b0; #1;
    vec_cnt++; if (pvalid[2] !== 1'b1) begin err_cnt++; $display("FAIL arst_buffered: got %b exp 1", pvalid[2]); end
    #2; rst_n = 1'b0; #1;
    vec_cnt++; if (pvalid[2] !== 1'b0 || pdata[95:64] !== 32'h0) begin err_cnt++; $display("FAIL arst_cleared: got v=%b d=%h exp 0 0", pvalid[2], pdata[95:64]); end
    vec_cnt++; if (rsp_ready !== 1'b1) begin err_cnt++; $display("FAIL arst_rsp_ready: got %b exp 1", rsp_ready); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_bypass();
    do_reset();
    @(negedge clk); pready = 4'b0010; rsp_valid = 1'b1; rsp_id = {2'd1, 5'd3}; rsp_data = 32'h1234; #1;
    vec_cnt++; if (rsp_ready !== 1'b1) begin err_cnt++; $display("FAIL byp_ready: got %b exp 1", rsp_ready); end
`ifdef SNITCH_ACC_RSP_BYPASS_EN
    vec_cnt++; if (pvalid[1] !== 1'b1 || pdata[63:32] !== 32'h1234 || pid[9:5] !== 5'd3) begin err_cnt++; $display("FAIL byp_same_cycle: got v=%b d=%h id=%0d exp 1 1234 3", pvalid[1], pdata[63:32], pid[9:5]); end
    @(negedge clk); rsp_valid = 1'b0; #1;
    vec_cnt++; if (pvalid[1] !== 1'b0) begin err_cnt++; $display("FAIL byp_not_stored: got %b exp 0", pvalid[1]); end
`else
    vec_cnt++; if (pvalid[1] !== 1'b0) begin err_cnt++; $display("FAIL nobyp_same_cycle: got %b exp 0", pvalid[1]); end
    @(negedge clk); rsp_valid = 1'b0; #1;
    vec_cnt++; if (pvalid[1] !== 1'b1 || pdata[63:32] !== 32'h1234 || pid[9:5] !== 5'd3) begin err_cnt++; $display("FAIL nobyp_next_cycle: got v=%b d=%h id=%0d exp 1 1234 3", pvalid[1], pdata[63:32], pid[9:5]); end
`endif
    @(negedge clk); #1;
    vec_cnt++; if (pvalid[1] !== 1'b0) begin err_cnt++; $display("FAIL byp_final_empty: got %b exp 0", pvalid[1]); end
    pready = '0;
  endtask

  initial begin
    test_reset();
    test_credit_block();
    test_stall_isolation();
    test_pop_issue();
    test_wrap();
    test_async_reset();
    test_bypass();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
